blink_rate_ctrl: RTL and testbench

Upstream control stage for the countdown timer in the lab3 programmable blinker.
- Turns two user push-buttons (faster / slower) into the timer's one-hot `load_value`.
- Generates the periodic `count_en` beat that paces the timer's countdown.
- Outputs connect directly to the timer's `load_value` and `count_en` inputs.

---
 rtl/blink_pkg.sv | 26 ++
 rtl/button_pulse.sv | 19 +
 rtl/blink_rate_ctrl.sv | 73 +++++++
 tb/tb_blink_rate_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared constants and step decode for the lab3 blinker rate control.
package blink_pkg;

  localparam int unsigned RATE_W           = 4;
  localparam int unsigned BEAT_DIV_DEFAULT = 32;

  localparam logic [RATE_W-1:0] RATE_FASTEST = 4'b0001;
  localparam logic [RATE_W-1:0] RATE_DEFAULT = 4'b0100;
  localparam logic [RATE_W-1:0] RATE_SLOWEST = 4'b1000;

  typedef enum logic [1:0] {
    STEP_NONE   = 2'd0,
    STEP_FASTER = 2'd1,
    STEP_SLOWER = 2'd2
  } step_e;

  // Opposing presses on the same edge cancel out.
  function automatic step_e decode_step(input logic press_f, input logic press_s);
    step_e s;
    s = STEP_NONE;
    if (press_f && !press_s) s = STEP_FASTER;
    if (press_s && !press_f) s = STEP_SLOWER;
    return s;
  endfunction

endpackage

// File: rtl/button_pulse.sv
// Rising-edge detector for a synchronized button level; one pulse per press.
module button_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // History resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/blink_rate_ctrl.sv
// Button-driven one-hot rate register plus the count_en beat prescaler.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int unsigned      WIDTH     = RATE_W,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RATE_DEFAULT),
  parameter int unsigned      BEAT_DIV  = BEAT_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             faster,
  input  logic             slower,
  output logic [WIDTH-1:0] load_value,
  output logic             count_en,
  output logic             changed
);

  localparam int unsigned      CNT_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);

  logic             press_f;
  logic             press_s;
  step_e            step_c;
  logic [WIDTH-1:0] load_nxt;
  logic             upd;
  logic [CNT_W-1:0] cnt;

  button_pulse u_faster (
    .clk   (clk),
    .rst   (rst),
    .level (faster),
    .pulse (press_f)
  );

  button_pulse u_slower (
    .clk   (clk),
    .rst   (rst),
    .level (slower),
    .pulse (press_s)
  );

  // Saturating one-hot step; a step into the rail leaves the value untouched.
  always_comb begin
    step_c   = decode_step(press_f, press_s);
    load_nxt = load_value;
    case (step_c)
      STEP_FASTER: if (!load_value[0])       load_nxt = load_value >> 1;
      STEP_SLOWER: if (!load_value[WIDTH-1]) load_nxt = load_value << 1;
      default:     load_nxt = load_value;
    endcase
    upd = (load_nxt != load_value);
  end

  // A rate change restarts the beat so the new rate begins with a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_value <= RESET_VAL;
      changed    <= 1'b0;
      cnt        <= '0;
    end else begin
      load_value <= load_nxt;
      changed    <= upd;
      if (upd)
        cnt <= '0;
      else if (run)
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign count_en = run & (cnt == CNT_LAST);

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Self-checking bench for blink_rate_ctrl: directed table, corner sequences, random vs. model.
module tb_blink_rate_ctrl;

  localparam int unsigned BD = 4;

  logic       clk = 1'b0;
  logic       rst, run, faster, slower;
  logic [3:0] load_value;
  logic       count_en, changed;

  int checks = 0;
  int errors = 0;

  blink_rate_ctrl #(.WIDTH(4), .RESET_VAL(4'b0100), .BEAT_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .faster     (faster),
    .slower     (slower),
    .load_value (load_value),
    .count_en   (count_en),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  // Reference model: rate as a bit index, beat phase as run-cycles since last restart.
  int  m_idx;
  int  m_elapsed;
  bit  m_changed;
  bit  m_fq, m_sq;
  bit  m_valid = 0;

  function automatic logic [3:0] m_load();
    return 4'(1 << m_idx);
  endfunction

  function automatic bit m_en(input bit ru);
    return ru && ((m_elapsed % BD) == BD - 1);
  endfunction

  task automatic model_edge(input bit r, input bit ru, input bit f, input bit s);
    bit pf, ps;
    int nidx;
    if (r) begin
      m_idx = 2; m_elapsed = 0; m_changed = 0; m_fq = 1; m_sq = 1; m_valid = 1;
    end else begin
      pf = f && !m_fq;
      ps = s && !m_sq;
      nidx = m_idx;
      if (pf && !ps) nidx = (m_idx > 0) ? m_idx - 1 : 0;
      if (ps && !pf) nidx = (m_idx < 3) ? m_idx + 1 : 3;
      m_changed = (nidx != m_idx);
      if (m_changed) m_elapsed = 0;
      else if (ru)   m_elapsed++;
      m_idx = nidx; m_fq = f; m_sq = s;
    end
  endtask

  // Drive inputs for one cycle and compare outputs against the model.
  task automatic drive(input bit r, input bit ru, input bit f, input bit s, input string tag);
    rst = r; run = ru; faster = f; slower = s;
    #1;
    if (m_valid) begin
      checks++;
      if (load_value !== m_load() || count_en !== m_en(ru) || changed !== m_changed) begin
        errors++;
        $display("FAIL model[%s] load=%b exp=%b en=%b exp=%b chg=%b exp=%b",
                 tag, load_value, m_load(), count_en, m_en(ru), changed, m_changed);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(rst, run, faster, slower);
    @(negedge clk);
  endtask

  task automatic cyc(input bit r, input bit ru, input bit f, input bit s, input string tag);
    drive(r, ru, f, s, tag);
    advance();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] el, input logic ee, input logic ec);
    checks++;
    if (load_value !== el || count_en !== ee || changed !== ec) begin
      errors++;
      $display("FAIL %s load=%b exp=%b en=%b exp=%b chg=%b exp=%b",
               tag, load_value, el, count_en, ee, changed, ec);
    end
  endtask

  typedef struct {
    bit         chk;
    bit         r, ru, f, s;
    logic [3:0] load;
    logic       en;
    logic       chg;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Reset, beats at cycles 4/8/12, one faster then one slower press.
    tbl.push_back('{0, 1, 0, 0, 0, 4'b0000, 1'b0, 1'b0});
    tbl.push_back('{1, 1, 0, 0, 0, 4'b0100, 1'b0, 1'b0});
    for (int c = 1; c <= 12; c++)
      tbl.push_back('{1, 0, 1, 0, 0, 4'b0100, logic'((c % 4) == 0), 1'b0});
    tbl.push_back('{1, 0, 1, 1, 0, 4'b0100, 1'b0, 1'b0});
    tbl.push_back('{1, 0, 1, 0, 0, 4'b0010, 1'b0, 1'b1});
    tbl.push_back('{1, 0, 1, 0, 0, 4'b0010, 1'b0, 1'b0});
    tbl.push_back('{1, 0, 1, 0, 0, 4'b0010, 1'b0, 1'b0});
    tbl.push_back('{1, 0, 1, 0, 0, 4'b0010, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 1, 0, 1, 4'b0010, 1'b0, 1'b0});
    tbl.push_back('{1, 0, 1, 0, 0, 4'b0100, 1'b0, 1'b1});

    rst = 1; run = 0; faster = 0; slower = 0;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].ru, tbl[i].f, tbl[i].s, $sformatf("tbl%0d", i));
      if (tbl[i].chk) expect_out($sformatf("vec%0d", i), tbl[i].load, tbl[i].en, tbl[i].chg);
      advance();
    end

    // Saturation toward fastest: third press is a no-op.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, "sat_f");
      drive(0, 1, 0, 0, "sat_f_rel");
      expect_out($sformatf("sat_f%0d", k), (k == 0) ? 4'b0010 : 4'b0001, m_en(1), (k < 2) ? 1'b1 : 1'b0);
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 1, "sat_s");
      cyc(0, 1, 0, 0, "sat_s_rel");
    end
    drive(0, 1, 0, 0, "sat_s_end");
    expect_out("sat_slowest", 4'b1000, m_en(1), 1'b0);
    advance();

    // Hold faster for 20 cycles: exactly one step.
    for (int k = 0; k < 20; k++) cyc(0, 1, 1, 0, "hold");
    drive(0, 1, 0, 0, "hold_rel");
    expect_out("hold_one_step", 4'b0100, m_en(1), 1'b0);
    advance();
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, "hold_gap");

    // Simultaneous presses cancel.
    cyc(0, 1, 1, 1, "both");
    drive(0, 1, 0, 0, "both_rel");
    expect_out("both_nochange", 4'b0100, m_en(1), 1'b0);
    advance();

    // run gating at counter=2, then beat two cycles after resume.
    cyc(1, 0, 0, 0, "gate_rst");
    cyc(0, 1, 0, 0, "gate_c0");
    cyc(0, 1, 0, 0, "gate_c1");
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0, "gate_off");
      expect_out("gate_no_beat", 4'b0100, 1'b0, 1'b0);
      advance();
    end
    drive(0, 1, 0, 0, "gate_resume1");
    expect_out("gate_resume1", 4'b0100, 1'b0, 1'b0);
    advance();
    drive(0, 1, 0, 0, "gate_resume2");
    expect_out("gate_resume2", 4'b0100, 1'b1, 1'b0);
    advance();

    // Reset coinciding with a press at 0010.
    cyc(0, 1, 1, 0, "rc_press");
    cyc(0, 1, 0, 0, "rc_rel");
    cyc(1, 1, 1, 0, "rc_rst_press");
    drive(0, 1, 1, 0, "rc_after");
    expect_out("rst_overrides_press", 4'b0100, 1'b0, 1'b0);
    advance();
    for (int k = 0; k < 2; k++) cyc(0, 1, 0, 0, "rc_gap");
    cyc(1, 1, 0, 0, "rc_phase_rst");
    drive(0, 1, 0, 0, "rc_phase");
    expect_out("rst_clears_cnt", 4'b0100, 1'b0, 1'b0);
    advance();

    // Faster held across reset release: no step.
    cyc(1, 1, 1, 0, "hr_rst");
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, "hr_hold");
    drive(0, 1, 0, 0, "hr_rel");
    expect_out("held_thru_reset", 4'b0100, m_en(1), 1'b0);
    advance();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bit r, ru, f, s;
      r  = ($urandom_range(0, 99) < 2);
      ru = ($urandom_range(0, 99) < 85);
      f  = ($urandom_range(0, 99) < 30);
      s  = ($urandom_range(0, 99) < 30);
      cyc(r, ru, f, s, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
